// File: rtl/rf_pkg.sv
// Shared definitions for the multiport register file and its pending-write scoreboard.
package rf_pkg;

    localparam int ZERO_REG = 0;

    // Largest count a PEND_W-bit pending counter may hold.
    function automatic int pend_max(input int pend_w);
        return (1 << pend_w) - 1;
    endfunction

endpackage

// File: rtl/rf_sb_counter.sv
// One register's pending-write counter: saturating increment, 0..2 decrements per cycle,
// clamps at zero and flags an underflow.
module rf_sb_counter
    import rf_pkg::*;
#(
    parameter int PEND_W = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       inc,
    input  logic [1:0] dec,
    output logic       at_max,
    output logic       busy_after,
    output logic       err
);

    localparam int SW = PEND_W + 1;
    localparam logic [SW-1:0] MAX = SW'(pend_max(PEND_W));

    logic [PEND_W-1:0] count;
    logic [SW-1:0]     count_w;
    logic [SW-1:0]     dec_w;
    logic [SW-1:0]     sum;

    assign count_w    = {1'b0, count};
    assign dec_w      = SW'(dec);
    assign at_max     = (count_w == MAX);
    // Busy only counts what survives this cycle's retires, not this cycle's issue.
    assign busy_after = (count_w > dec_w);

    always_comb begin
        sum = count_w + SW'(inc && !at_max);
        err = (sum < dec_w);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (err) begin
            count <= '0;
        end else begin
            count <= PEND_W'(sum - dec_w);
        end
    end

endmodule

// File: rtl/rf_multiport_sb.sv
// NUM_RD-read / 2-write register file with same-cycle write bypass and a per-register
// pending-write scoreboard feeding the issue stage.
module rf_multiport_sb
    import rf_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NUM_RD = 2,
    parameter int PEND_W = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    output logic [NUM_RD-1:0]        rd_busy,
    input  logic [1:0]               wr_en,
    input  logic [2*ADDR_W-1:0]      wr_addr,
    input  logic [2*DATA_W-1:0]      wr_data,
    input  logic [1:0]               wr_retire,
    input  logic                     iss_en,
    input  logic [ADDR_W-1:0]        iss_addr,
    output logic                     iss_stall,
    output logic                     sb_err
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] ZERO_IDX = ADDR_W'(ZERO_REG);

    logic [DATA_W-1:0] mem [DEPTH];

    logic [ADDR_W-1:0] wa0, wa1;
    logic [DATA_W-1:0] wd0, wd1;
    logic              we0, we1;
    logic              ret0, ret1;

    assign wa0  = wr_addr[0 +: ADDR_W];
    assign wa1  = wr_addr[ADDR_W +: ADDR_W];
    assign wd0  = wr_data[0 +: DATA_W];
    assign wd1  = wr_data[DATA_W +: DATA_W];
    assign we0  = wr_en[0] && (wa0 != ZERO_IDX);
    assign we1  = wr_en[1] && (wa1 != ZERO_IDX);
    assign ret0 = wr_en[0] && wr_retire[0];
    assign ret1 = wr_en[1] && wr_retire[1];

    // Lane 1 is applied last so it wins a same-index collision.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (we0) mem[wa0] <= wd0;
            if (we1) mem[wa1] <= wd1;
        end
    end

    logic [DEPTH-1:0] at_max_v;
    logic [DEPTH-1:0] busy_v;
    logic [DEPTH-1:0] err_v;

    assign at_max_v[0] = 1'b0;
    assign busy_v[0]   = 1'b0;
    assign err_v[0]    = 1'b0;

    // Stall is decided from the pre-retire count, so a same-cycle retire cannot unblock it.
    assign iss_stall = iss_en && at_max_v[iss_addr];

    for (genvar r = 1; r < DEPTH; r++) begin : g_sb
        logic       inc;
        logic [1:0] dec;

        assign inc = iss_en && (iss_addr == ADDR_W'(r)) && !iss_stall;
        assign dec = {1'b0, ret0 && (wa0 == ADDR_W'(r))}
                   + {1'b0, ret1 && (wa1 == ADDR_W'(r))};

        rf_sb_counter #(
            .PEND_W(PEND_W)
        ) u_cnt (
            .clk       (clk),
            .rst       (rst),
            .inc       (inc),
            .dec       (dec),
            .at_max    (at_max_v[r]),
            .busy_after(busy_v[r]),
            .err       (err_v[r])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sb_err <= 1'b0;
        end else if (|err_v) begin
            sb_err <= 1'b1;
        end
    end

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [ADDR_W-1:0] ra;
        logic [DATA_W-1:0] rv;

        assign ra = rd_addr[k*ADDR_W +: ADDR_W];

        always_comb begin
            rv = mem[ra];
            if (ra == ZERO_IDX) begin
                rv = '0;
            end else if (we1 && (wa1 == ra)) begin
                rv = wd1;
            end else if (we0 && (wa0 == ra)) begin
                rv = wd0;
            end
        end

        assign rd_data[k*DATA_W +: DATA_W] = rv;
        assign rd_busy[k]                  = busy_v[ra];
    end

endmodule
